// File: rtl/uart_rx_pkg.sv
// Shared UART constants: FSM state encodings, default bit timing, and width helpers
// used by uart_rx and the other serial blocks in this slice.
package uart_rx_pkg;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 16;
    localparam int UART_DATA_LENGTH_DEFAULT  = 8;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    // Counter width that never collapses to zero bits for a range of one value.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bundle: the received byte, its strobes, and the busy flag.
interface uart_rx_if #(
    parameter int UART_DATA_LENGTH = 8
);
    logic [UART_DATA_LENGTH-1:0] data_o;
    logic                        data_valid_strb_o;
    logic                        frame_err_strb_o;
    logic                        busy_o;

    modport master (
        output data_o,
        output data_valid_strb_o,
        output frame_err_strb_o,
        output busy_o
    );

    modport slave (
        input data_o,
        input data_valid_strb_o,
        input frame_err_strb_o,
        input busy_o
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to RESET_VALUE.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments make meta_q->sync_q a true two-stage pipeline;
    // blocking ones here would collapse it into a single flop.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style frames (configurable data length), LSB first, mid-bit sampling,
// with a one-cycle strobe for each good frame and for each frame whose stop bit is low.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int UART_DATA_LENGTH = UART_DATA_LENGTH_DEFAULT,
    parameter int CLKS_PER_BIT     = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic      clk_i,
    input  logic      reset_ni,
    input  logic      rx_i,
    uart_rx_if.master rx_if
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = idx_width(UART_DATA_LENGTH);

    localparam logic [CNT_W-1:0] BAUD_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_LENGTH - 1);

    logic                        rx;
    logic [1:0]                  state_q;
    logic [1:0]                  state_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [IDX_W-1:0]            bit_idx_q;
    logic [UART_DATA_LENGTH-1:0] shift_q;
    logic [UART_DATA_LENGTH-1:0] data_q;
    logic                        valid_q;
    logic                        ferr_q;
    logic                        line_high_seen_q;

    logic start_accept;
    logic data_sample;
    logic stop_sample;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync_rx (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .d_i     (rx_i),
        .q_o     (rx)
    );

    // A start is only accepted once the line has been seen idle, so a held-low
    // break or a frame already running at reset release cannot retrigger.
    assign start_accept = (state_q == ST_IDLE) && !rx && line_high_seen_q;
    assign data_sample  = (state_q == ST_DATA) && (cnt_q == BAUD_LAST);
    assign stop_sample  = (state_q == ST_STOP) && (cnt_q == BAUD_LAST);

    // NOTE: state_d gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_accept) state_d = ST_START;
            ST_START: if (cnt_q == BAUD_MID) state_d = rx ? ST_IDLE : ST_DATA;
            ST_DATA:  if (data_sample && (bit_idx_q == IDX_LAST)) state_d = ST_STOP;
            ST_STOP:  if (stop_sample) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q <= state_d;

            if ((state_d != state_q) || (state_q == ST_IDLE) || (cnt_q == BAUD_LAST)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (state_q == ST_START) begin
                bit_idx_q <= '0;
            end else if (data_sample) begin
                bit_idx_q <= (bit_idx_q == IDX_LAST) ? '0 : bit_idx_q + IDX_W'(1);
            end
        end
    end

    // NOTE: the shift register and output byte are ordinary flops and are reset,
    // so data_o reads 0 rather than X before the first frame arrives.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (data_sample) begin
                shift_q[bit_idx_q] <= rx;
            end
            if (stop_sample && rx) begin
                data_q <= shift_q;
            end
            valid_q <= stop_sample && rx;
            ferr_q  <= stop_sample && !rx;
        end
    end

    // Cleared on a low stop bit too, so a break must go high before the next start.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            line_high_seen_q <= 1'b0;
        end else if (start_accept || (stop_sample && !rx)) begin
            line_high_seen_q <= 1'b0;
        end else if (rx) begin
            line_high_seen_q <= 1'b1;
        end
    end

    assign rx_if.data_o            = data_q;
    assign rx_if.data_valid_strb_o = valid_q;
    assign rx_if.frame_err_strb_o  = ferr_q;
    assign rx_if.busy_o            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model with a strobe scoreboard.
module tb_uart_rx;

    localparam int DL  = 8;
    localparam int CPB = 16;
    localparam int LAT = 2 + CPB / 2 + (DL + 1) * CPB;

    typedef struct {
        logic [DL-1:0] data;
        bit            stop_ok;
        int            gap;
    } vec_t;

    typedef struct {
        bit            is_err;
        logic [DL-1:0] data;
        longint        cyc;
    } ev_t;

    logic          clk      = 1'b0;
    logic          reset_ni = 1'b0;
    logic          rx_i     = 1'b1;
    longint        cyc      = 0;
    int            n_vec    = 0;
    int            n_miss   = 0;
    logic [DL-1:0] last_data = '0;
    ev_t           exp_q[$];
    ev_t           act_q[$];

    uart_rx_if #(.UART_DATA_LENGTH(DL)) rx_if ();

    uart_rx #(
        .UART_DATA_LENGTH(DL),
        .CLKS_PER_BIT    (CPB)
    ) dut (
        .clk_i   (clk),
        .reset_ni(reset_ni),
        .rx_i    (rx_i),
        .rx_if   (rx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint exp, input longint tol);
        n_vec++;
        if ((act < exp - tol) || (act > exp + tol)) begin
            n_miss++;
            $display("FAIL %s: got cycle %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (rx_if.data_valid_strb_o === 1'b1 || rx_if.frame_err_strb_o === 1'b1) begin
            check("strobe_exclusive", {63'd0, rx_if.data_valid_strb_o & rx_if.frame_err_strb_o}, 64'd0);
            e.is_err = rx_if.frame_err_strb_o;
            e.data   = rx_if.data_o;
            e.cyc    = cyc;
            act_q.push_back(e);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_i = v;
        tick(CPB);
    endtask

    // Reference: a good stop bit yields the byte; a low stop bit yields an error
    // strobe carrying the unchanged previous byte; both land LAT cycles after the fall.
    task automatic expect_frame(input logic [DL-1:0] b, input bit stop_ok);
        ev_t e;
        e.is_err = !stop_ok;
        e.data   = stop_ok ? b : last_data;
        e.cyc    = cyc + 1 + LAT;
        exp_q.push_back(e);
        if (stop_ok) last_data = b;
    endtask

    task automatic send_frame(input logic [DL-1:0] b, input bit stop_ok, input int gap);
        expect_frame(b, stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < DL; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        rx_i = 1'b1;
        tick(gap);
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check($sformatf("%s_kind%0d", tag, i), {63'd0, act_q[i].is_err}, {63'd0, exp_q[i].is_err});
            check($sformatf("%s_data%0d", tag, i), 64'(act_q[i].data), 64'(exp_q[i].data));
            check_tol($sformatf("%s_time%0d", tag, i), act_q[i].cyc, exp_q[i].cyc, 1);
        end
        check({tag, "_data_o"}, 64'(rx_if.data_o), 64'(last_data));
        check({tag, "_busy"}, {63'd0, rx_if.busy_o}, 64'd0);
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1);
    end

    initial begin : stimulus
        vec_t tbl[7];
        ev_t  brk;
        tbl[0] = '{8'hA5, 1'b1, 20};
        tbl[1] = '{8'h3C, 1'b1, 0};
        tbl[2] = '{8'hC3, 1'b1, 12};
        tbl[3] = '{8'h55, 1'b0, 12};
        tbl[4] = '{8'h00, 1'b1, 5};
        tbl[5] = '{8'hFF, 1'b1, 0};
        tbl[6] = '{8'h81, 1'b1, 10};

        reset_ni = 1'b0;
        rx_i     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data_o", 64'(rx_if.data_o), 64'd0);
        check("reset_valid", {63'd0, rx_if.data_valid_strb_o}, 64'd0);
        check("reset_ferr", {63'd0, rx_if.frame_err_strb_o}, 64'd0);
        check("reset_busy", {63'd0, rx_if.busy_o}, 64'd0);
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        tick(5);

        for (int i = 0; i < 7; i++) send_frame(tbl[i].data, tbl[i].stop_ok, tbl[i].gap);
        tick(4);
        compare_events("table");

        // Short low pulse: START is entered, then abandoned at mid start bit.
        rx_i = 1'b0;
        tick(4);
        check("glitch_busy", {63'd0, rx_if.busy_o}, 64'd1);
        tick(1);
        rx_i = 1'b1;
        tick(30);
        compare_events("glitch");

        // Break: one error strobe, then nothing until the line goes high and falls again.
        brk.is_err = 1'b1;
        brk.data   = last_data;
        brk.cyc    = cyc + 1 + LAT;
        exp_q.push_back(brk);
        rx_i = 1'b0;
        tick(20 * CPB);
        rx_i = 1'b1;
        tick(5);
        send_frame(8'h5A, 1'b1, 10);
        compare_events("break");

        // Reset mid-frame during data bit 4 of 0xFF; the tail must not be received.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx_i = 1'b1;
        tick(8);
        reset_ni = 1'b0;
        tick(2);
        check("midreset_busy", {63'd0, rx_if.busy_o}, 64'd0);
        check("midreset_data_o", 64'(rx_if.data_o), 64'd0);
        reset_ni  = 1'b1;
        last_data = '0;
        tick(4 + 3 * CPB + CPB);
        tick(5);
        send_frame(8'h12, 1'b1, 10);
        compare_events("reset");

        for (int i = 0; i < 24; i++) begin
            logic [DL-1:0] b;
            bit            ok;
            int            gap;
            b   = DL'($urandom_range(0, (1 << DL) - 1));
            ok  = ($urandom_range(0, 7) != 0);
            gap = ok ? int'($urandom_range(0, 6)) : int'($urandom_range(3, 8));
            send_frame(b, ok, gap);
        end
        tick(4);
        compare_events("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter UART_DATA_LENGTH, default 8, giving data bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clk_i cycles per bit; legal values are even and at least 4.
REQ-003 clk_i  input  1  single clock; all state changes occur on its rising edge.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 rx_i  input  1  serial line; idle high; asynchronous to clk_i.
REQ-006 data_o  output  UART_DATA_LENGTH  last correctly framed byte; bit 0 is the first bit received.
REQ-007 data_valid_strb_o  output  1  one-cycle pulse; data_o holds a new valid byte; drives the programmer's data_valid_strb_i.
REQ-008 frame_err_strb_o  output  1  one-cycle pulse; the stop bit was sampled low.
REQ-009 busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-010 rx_i SHALL pass through a 2-flop synchronizer that resets to 1; every "rx" below means the synchronized value.
REQ-011 The state machine SHALL have four states: IDLE, START, DATA, STOP.
REQ-012 An internal baud counter SHALL count 0..CLKS_PER_BIT-1 and clear on every state change.
REQ-013 An internal bit index SHALL count 0..UART_DATA_LENGTH-1.
REQ-014 IDLE -> START SHALL occur on the first cycle rx=0.
REQ-015 In START, when the counter reaches CLKS_PER_BIT/2-1 (mid start bit):
- rx=0 -> DATA, with bit index cleared;
- rx=1 -> IDLE, treated as a glitch, with no strobe.
REQ-016 In DATA, each time the counter reaches CLKS_PER_BIT-1:
- rx SHALL be shifted into a shift register at position bit index (LSB first);
- the bit index SHALL increment;
- after bit UART_DATA_LENGTH-1 the state SHALL go to STOP.
REQ-017 In STOP, when the counter reaches CLKS_PER_BIT-1 (mid stop bit), the state SHALL return to IDLE, and:
- rx=1: the shift register SHALL load into data_o and data_valid_strb_o SHALL pulse high on the next cycle;
- rx=0: frame_err_strb_o SHALL pulse instead, and data_o SHALL be left unchanged.
REQ-018 Latency SHALL be fixed: the strobe asserts 2 + CLKS_PER_BIT/2 + (UART_DATA_LENGTH+1)*CLKS_PER_BIT cycles after the rx_i falling edge, ±1 cycle for synchronizer phase.
REQ-019 data_valid_strb_o and frame_err_strb_o SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-020 Back-to-back frames SHALL be received with no loss: after the mid-stop sample, IDLE accepts a new start edge on the next cycle.
REQ-021 rx held low (break) SHALL produce one frame_err_strb_o pulse, followed by a new START only after rx returns high and then falls again; in IDLE, START is entered only on rx=0 after rx=1 has been seen.
REQ-022 data_o SHALL remain stable between strobes.

Reset
REQ-023 While reset_ni=0, the block SHALL be in IDLE with:
- counter, bit index, shift register and data_o at 0;
- both strobes and busy_o at 0;
- synchronizer flops at 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no strobe.
REQ-025 After reset release, the block SHALL wait for a fresh falling edge, so a frame already in progress is not received.

Structure
REQ-026 The state encodings (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11) and the default CLKS_PER_BIT SHALL live in the shared UART constants include file used by uart_rx and programmer.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, reset value parameter).
REQ-028 The counter widths SHALL be $clog2(CLKS_PER_BIT) for the baud counter and $clog2(UART_DATA_LENGTH) for the bit index.

Verification
REQ-029 Frame 0xA5 at CLKS_PER_BIT=16 -> data_o=0xA5 with one data_valid_strb_o pulse within ±1 cycle of 154 cycles after the start edge; busy_o low after.
REQ-030 Frames 0x3C then 0xC3 back-to-back (stop then start with no gap) -> two strobes 160 cycles apart, carrying 0x3C then 0xC3.
REQ-031 rx low for 5 cycles then high (glitch) -> return to IDLE, no strobe, data_o unchanged.
REQ-032 Frame 0x55 with stop bit low -> frame_err_strb_o one pulse, data_valid_strb_o stays 0, data_o keeps its previous value.
REQ-033 reset_ni pulsed low during data bit 4 of 0xFF -> no strobe; the next complete frame 0x12 is received correctly.
REQ-034 Chained with programmer, bytes 0x1F then 0x2E -> memory addresses 0..3 written with 1, F, 2, E.
